alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, default 0, requester holding priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester N granted this cycle (combinational).
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands of requester N.
REQ-007 req0_op / req1_op  input  3  ALU control code of requester N (000 add, 001 sub, 010 and, 011 or, 101 slt).
REQ-008 alu_srca, alu_srcb  output  32  operands driven to the shared ALU.
REQ-009 alu_ctrl  output  3  control code driven to the shared ALU.
REQ-010 alu_result  input  32, alu_zero  input  1  combinational ALU outputs.
REQ-011 rsp_valid  output  1  registered response held.
REQ-012 rsp_id  output  1  requester owning the held response.
REQ-013 rsp_result  output  32, rsp_zero  output  1  registered ALU result and zero flag.
REQ-014 rsp_ready  input  1  owner (rsp_id) accepts the response this cycle.

Function
REQ-015 State machine SHALL have two states: IDLE (no response held) and RESP (response held, rsp_valid=1).
REQ-016 Grant window SHALL be open when state is IDLE, or RESP with rsp_ready=1 in the same cycle; closed otherwise.
REQ-017 With window open and exactly one reqN_valid, SHALL grant requester N.
REQ-018 With window open and both valid, SHALL grant the requester indicated by the priority pointer.
REQ-019 After any grant, pointer SHALL point to the non-granted requester (round-robin); pointer unchanged when no grant.
REQ-020 At most one reqN_ready SHALL be high per cycle; reqN_ready high only if reqN_valid high and window open.
REQ-021 During a grant, alu_srca/alu_srcb/alu_ctrl SHALL equal the granted requester's a/b/op unmodified; otherwise all SHALL be 0.
REQ-022 On a grant edge, rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_id<=granted index, state<=RESP; latency request-to-response exactly 1 cycle.
REQ-023 In RESP with rsp_ready=1 and no grant, state SHALL return to IDLE; rsp_valid<=0; rsp_result/rsp_zero/rsp_id hold last values.
REQ-024 In RESP with rsp_ready=1 and a grant, the new response SHALL replace the old on the same edge (back-to-back throughput 1 op/cycle).
REQ-025 In RESP with rsp_ready=0, no grant SHALL occur; all response outputs and pointer SHALL hold.
REQ-026 rsp_ready in IDLE SHALL be ignored.
REQ-027 Unsupported op codes (100, 110, 111) SHALL be passed through unchanged; the arbiter does not filter them.
REQ-028 A requester dropping valid without grant SHALL incur no state change.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, pointer PRIO_INIT.
REQ-030 Reset mid-operation SHALL discard any held response without handshake; req0_ready/req1_ready SHALL be 0 while rst_n low.
REQ-031 First grant SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-032 Single add: req0 a=5, b=7, op=000, rsp_ready=1 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
REQ-033 Contention, PRIO_INIT=0: both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1 at one response per cycle.
REQ-034 Backpressure: response held, rsp_ready=0 for 3 cycles with req1 valid -> req1_ready=0 and rsp_* stable for 3 cycles; grant on cycle rsp_ready rises.
REQ-035 Zero flag: req1 a=9, b=9, op=001 -> rsp_result=0, rsp_zero=1, rsp_id=1.
REQ-036 Reset mid-op: rst_n low while rsp_valid=1 -> rsp_valid=0, rsp_result=0 immediately (before next edge); pointer returns to PRIO_INIT.
REQ-037 Idle outputs: no valid requests -> alu_srca=0, alu_srcb=0, alu_ctrl=000, both ready low, pointer unchanged.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// The granted requester's operands are steered to the ALU, and the ALU
// outputs are captured into a one-deep response register on the grant edge.
//
// Handshakes:
//  - Request side: reqN_ready is high only while reqN_valid is high and the
//    grant window is open. A cycle with both reqN_valid and reqN_ready high
//    is a grant.
//  - Response side: rsp_valid is high while a response is held, and
//    rsp_ready accepts it. While the response is not accepted it stays
//    stable, and rsp_ready is ignored when nothing is held.
module alu_arbiter #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic [31:0] alu_srca,
  output logic [31:0] alu_srcb,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  input  logic        rsp_ready,
  output logic [0:0]  dbg_state_o,
  output logic        dbg_ptr_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        win;
  logic        gnt0, gnt1;

  // Grant decision: the window opens when nothing is held or the held
  // response leaves this cycle. Qualifying with rst_n keeps both readies low
  // during reset.
  always_comb begin
    win  = (state_q == ST_IDLE) || rsp_ready;
    gnt0 = rst_n && win && req0_valid && (!req1_valid || (ptr_q == 1'b0));
    gnt1 = rst_n && win && req1_valid && (!req0_valid || (ptr_q == 1'b1));
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Drive the ALU from the granted requester and drive zeros otherwise, so
  // that the idle bus is quiet.
  always_comb begin
    alu_srca = 32'd0;
    alu_srcb = 32'd0;
    alu_ctrl = 3'b000;
    if (gnt1) begin
      alu_srca = req1_a;
      alu_srcb = req1_b;
      alu_ctrl = req1_op;
    end else if (gnt0) begin
      alu_srca = req0_a;
      alu_srcb = req0_b;
      alu_ctrl = req0_op;
    end
  end

  // Next-state logic. A grant loads a new response, which replaces any
  // response that is leaving in the same cycle. An accepted response with no
  // new grant returns the FSM to IDLE. The payload fields hold their values.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    if (gnt0 || gnt1) begin
      state_d      = ST_RESP;
      ptr_d        = gnt0;
      rsp_id_d     = gnt1;
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_zero;
    end else if ((state_q == ST_RESP) && rsp_ready) begin
      state_d = ST_IDLE;
    end
  end

  // State and response registers. Reset is asynchronous and discards any
  // held response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= PRIO_INIT;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule
